// File: rtl/pipe_reg_elastic.sv
// Elastic DEPTH-deep pipeline register with valid/ready handshake, bubble collapse and flush.
// Sits between two CPU pipeline stages; empty stages take the entry behind them so gaps close under stall.
module pipe_reg_elastic #(
    parameter int                DATA_W     = 32,
    parameter int                DEPTH      = 1,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = '0
) (
    input  logic                         CLK,
    input  logic                         nRST,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_W-1:0]            in_data,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_data,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int OCC_W = $clog2(DEPTH+1);

    generate
        if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
            $error("pipe_reg_elastic: DEPTH must be in 1..4");
        end
    endgenerate

    logic [DEPTH-1:0]             r_v;
    logic [DEPTH-1:0][DATA_W-1:0] r_d;
    logic [OCC_W-1:0]             r_occ;

    logic [DEPTH-1:0]             w_adv;
    logic [DEPTH-1:0]             w_v_nxt;
    logic [DEPTH-1:0][DATA_W-1:0] w_d_nxt;
    logic                         w_xfer;
    logic                         w_out_hs;

    // Advance is resolved from the output backwards: a stage moves if the one ahead is empty or moving.
    always_comb begin
        w_adv            = '0;
        w_adv[DEPTH-1]   = r_v[DEPTH-1] & out_ready;
        for (int k = DEPTH - 2; k >= 0; k--) begin
            w_adv[k] = r_v[k] & (~r_v[k+1] | w_adv[k+1]);
        end
    end

    assign in_ready = ~nRST | (~flush & (~r_v[0] | w_adv[0]));
    assign w_xfer   = in_valid & in_ready;
    assign w_out_hs = r_v[DEPTH-1] & out_ready;

    always_comb begin
        w_v_nxt = r_v;
        w_d_nxt = r_d;
        for (int k = DEPTH - 1; k >= 1; k--) begin
            if (w_adv[k-1]) begin
                w_v_nxt[k] = 1'b1;
                w_d_nxt[k] = r_d[k-1];
            end else if (w_adv[k]) begin
                w_v_nxt[k] = 1'b0;
            end
        end
        if (w_xfer) begin
            w_v_nxt[0] = 1'b1;
            w_d_nxt[0] = in_data;
        end else if (w_adv[0]) begin
            w_v_nxt[0] = 1'b0;
        end
    end

    // Flush reloads bubbles so downstream control fields decode as a NOP.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_v   <= '0;
            r_d   <= {DEPTH{BUBBLE_VAL}};
            r_occ <= '0;
        end else if (flush) begin
            r_v   <= '0;
            r_d   <= {DEPTH{BUBBLE_VAL}};
            r_occ <= '0;
        end else begin
            r_v   <= w_v_nxt;
            r_d   <= w_d_nxt;
            r_occ <= r_occ + OCC_W'(w_xfer) - OCC_W'(w_out_hs);
        end
    end

    assign out_valid = r_v[DEPTH-1];
    assign out_data  = r_d[DEPTH-1];
    assign occupancy = r_occ;

endmodule

// File: tb/tb_pipe_reg_elastic.sv
// Bench for pipe_reg_elastic: hand vectors, flush/reset corners, randomized run against a queue model.
module tb_pipe_reg_elastic;

    localparam int D = 3;

    logic       CLK = 1'b0;
    logic       nRST = 1'b0;
    logic       iv = 1'b0, fl = 1'b0, ordy = 1'b0;
    logic [7:0] id = 8'h00;
    logic       ir, ov;
    logic [7:0] od;
    logic [1:0] occ;

    logic       u_iv = 1'b0, u_fl = 1'b0, u_or = 1'b0;
    logic [7:0] u_id = 8'h00;
    logic       u_ir, u_ov;
    logic [7:0] u_od;
    logic [0:0] u_occ;

    always #5 CLK = ~CLK;

    pipe_reg_elastic #(.DATA_W(8), .DEPTH(D), .BUBBLE_VAL(8'h00)) dut (
        .CLK(CLK), .nRST(nRST), .in_valid(iv), .in_ready(ir), .in_data(id), .flush(fl),
        .out_valid(ov), .out_ready(ordy), .out_data(od), .occupancy(occ)
    );

    pipe_reg_elastic #(.DATA_W(8), .DEPTH(1), .BUBBLE_VAL(8'h00)) dut1 (
        .CLK(CLK), .nRST(nRST), .in_valid(u_iv), .in_ready(u_ir), .in_data(u_id), .flush(u_fl),
        .out_valid(u_ov), .out_ready(u_or), .out_data(u_od), .occupancy(u_occ)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: an ordered list of entries with their stage positions; head leaves from position D-1.
    logic [7:0] m_d[$];
    int         m_p[$];

    function automatic bit m_ready(input bit o, input bit f);
        int lim, s, np;
        if (f) return 1'b0;
        s   = (m_p.size() > 0 && m_p[0] == D - 1 && o) ? 1 : 0;
        lim = D - 1;
        for (int i = s; i < m_p.size(); i++) begin
            np  = (m_p[i] + 1 < lim) ? m_p[i] + 1 : lim;
            lim = np - 1;
        end
        return lim >= 0;
    endfunction

    task automatic m_step(input bit v, input logic [7:0] d, input bit o, input bit f);
        bit rdy;
        int lim;
        rdy = m_ready(o, f);
        if (f) begin
            m_d.delete();
            m_p.delete();
        end else begin
            if (m_p.size() > 0 && m_p[0] == D - 1 && o) begin
                void'(m_d.pop_front());
                void'(m_p.pop_front());
            end
            lim = D - 1;
            foreach (m_p[i]) begin
                m_p[i] = (m_p[i] + 1 < lim) ? m_p[i] + 1 : lim;
                lim    = m_p[i] - 1;
            end
            if (v && rdy) begin
                m_d.push_back(d);
                m_p.push_back(0);
            end
        end
    endtask

    function automatic bit m_ov();
        return m_p.size() > 0 && m_p[0] == D - 1;
    endfunction

    task automatic drive(input bit v, input logic [7:0] d, input bit o, input bit f);
        iv = v; id = d; ordy = o; fl = f;
        #1;
    endtask

    task automatic tick();
        @(posedge CLK);
        m_step(iv, id, ordy, fl);
        @(negedge CLK);
    endtask

    typedef struct {
        bit         v;
        logic [7:0] d;
        bit         o;
        bit         f;
        bit         e_ir;
        bit         e_ov;
        logic [7:0] e_od;
        int         e_occ;
    } vec_t;

    vec_t tbl[$];

    initial begin
        bit         rv, ro, rf;
        logic [7:0] rd;

        // streaming A1..A4, out_ready high
        tbl.push_back('{1, 8'hA1, 1, 0, 1, 0, 8'h00, 0});
        tbl.push_back('{1, 8'hA2, 1, 0, 1, 0, 8'h00, 1});
        tbl.push_back('{1, 8'hA3, 1, 0, 1, 0, 8'h00, 2});
        tbl.push_back('{1, 8'hA4, 1, 0, 1, 1, 8'hA1, 3});
        tbl.push_back('{0, 8'h00, 1, 0, 1, 1, 8'hA2, 3});
        tbl.push_back('{0, 8'h00, 1, 0, 1, 1, 8'hA3, 2});
        tbl.push_back('{0, 8'h00, 1, 0, 1, 1, 8'hA4, 1});
        tbl.push_back('{0, 8'h00, 1, 0, 1, 0, 8'h00, 0});
        // backpressure and full
        tbl.push_back('{1, 8'h10, 0, 0, 1, 0, 8'h00, 0});
        tbl.push_back('{1, 8'h11, 0, 0, 1, 0, 8'h00, 1});
        tbl.push_back('{1, 8'h12, 0, 0, 1, 0, 8'h00, 2});
        tbl.push_back('{1, 8'h13, 0, 0, 0, 1, 8'h10, 3});
        tbl.push_back('{1, 8'h13, 1, 0, 1, 1, 8'h10, 3});
        tbl.push_back('{0, 8'h00, 1, 0, 1, 1, 8'h11, 3});
        tbl.push_back('{0, 8'h00, 1, 0, 1, 1, 8'h12, 2});
        tbl.push_back('{0, 8'h00, 1, 0, 1, 1, 8'h13, 1});
        tbl.push_back('{0, 8'h00, 0, 0, 1, 0, 8'h00, 0});
        // bubble collapse under stall
        tbl.push_back('{1, 8'h20, 0, 0, 1, 0, 8'h00, 0});
        tbl.push_back('{0, 8'h00, 0, 0, 1, 0, 8'h00, 1});
        tbl.push_back('{1, 8'h21, 0, 0, 1, 0, 8'h00, 1});
        tbl.push_back('{0, 8'h00, 0, 0, 1, 1, 8'h20, 2});
        tbl.push_back('{0, 8'h00, 0, 0, 1, 1, 8'h20, 2});
        tbl.push_back('{0, 8'h00, 1, 0, 1, 1, 8'h20, 2});
        tbl.push_back('{0, 8'h00, 1, 0, 1, 1, 8'h21, 1});
        tbl.push_back('{0, 8'h00, 0, 0, 1, 0, 8'h00, 0});

        // reset values, checked mid-cycle while nRST is low
        #3;
        chk("rst_ov", 32'(ov), 32'd0);
        chk("rst_od", 32'(od), 32'h00);
        chk("rst_occ", 32'(occ), 32'd0);
        chk("rst_ir", 32'(ir), 32'd1);
        chk("rst_u_ov", 32'(u_ov), 32'd0);
        chk("rst_u_occ", 32'(u_occ), 32'd0);
        @(negedge CLK);
        nRST = 1'b1;
        #1;
        chk("rel_ir", 32'(ir), 32'd1);

        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].o, tbl[i].f);
            chk($sformatf("v%0d_ir", i), 32'(ir), 32'(tbl[i].e_ir));
            chk($sformatf("v%0d_ov", i), 32'(ov), 32'(tbl[i].e_ov));
            if (tbl[i].e_ov) chk($sformatf("v%0d_od", i), 32'(od), 32'(tbl[i].e_od));
            chk($sformatf("v%0d_occ", i), 32'(occ), 32'(tbl[i].e_occ));
            tick();
        end

        // flush with a full pipe, simultaneous output handshake and offered input
        drive(1, 8'h30, 0, 0); tick();
        drive(1, 8'h31, 0, 0); tick();
        drive(1, 8'h32, 0, 0); tick();
        drive(1, 8'hFF, 1, 1);
        chk("fl_occ_pre", 32'(occ), 32'd3);
        chk("fl_od_pre", 32'(od), 32'h30);
        chk("fl_ir", 32'(ir), 32'd0);
        tick();
        drive(0, 8'h00, 1, 0);
        chk("fl_ov", 32'(ov), 32'd0);
        chk("fl_occ", 32'(occ), 32'd0);
        chk("fl_od_bubble", 32'(od), 32'h00);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("fl_drain%0d_ov", i), 32'(ov), 32'd0);
        end

        // asynchronous reset mid-operation
        drive(1, 8'h40, 0, 0); tick();
        drive(1, 8'h41, 0, 0); tick();
        drive(0, 8'h00, 0, 0);
        chk("mr_occ_pre", 32'(occ), 32'd2);
        #1 nRST = 1'b0;
        #1;
        chk("mr_ov", 32'(ov), 32'd0);
        chk("mr_occ", 32'(occ), 32'd0);
        chk("mr_od", 32'(od), 32'h00);
        chk("mr_ir", 32'(ir), 32'd1);
        m_d.delete();
        m_p.delete();
        #1 nRST = 1'b1;
        @(negedge CLK);
        drive(1, 8'h55, 1, 0);
        chk("mr55_ir", 32'(ir), 32'd1);
        tick();
        drive(0, 8'h00, 1, 0);
        chk("mr55_occ1", 32'(occ), 32'd1);
        tick();
        chk("mr55_ov_early", 32'(ov), 32'd0);
        tick();
        chk("mr55_ov", 32'(ov), 32'd1);
        chk("mr55_od", 32'(od), 32'h55);
        tick();
        chk("mr55_done", 32'(occ), 32'd0);

        // randomized run against the model
        for (int c = 0; c < 400; c++) begin
            rv = 1'($urandom_range(0, 1));
            ro = 1'($urandom_range(0, 3) != 0);
            rf = 1'($urandom_range(0, 24) == 0);
            rd = 8'($urandom);
            drive(rv, rd, ro, rf);
            chk("rnd_ir", 32'(ir), 32'(m_ready(ro, rf)));
            chk("rnd_ov", 32'(ov), 32'(m_ov()));
            if (m_ov()) chk("rnd_od", 32'(od), 32'(m_d[0]));
            chk("rnd_occ", 32'(occ), 32'(m_d.size()));
            tick();
        end
        drive(0, 8'h00, 0, 0);

        // DEPTH=1: back-to-back flow, then full / pass-through
        u_or = 1'b1; u_iv = 1'b1; u_id = 8'h01;
        #1;
        chk("d1_ir0", 32'(u_ir), 32'd1);
        @(posedge CLK); @(negedge CLK);
        u_id = 8'h02;
        #1;
        chk("d1_ir1", 32'(u_ir), 32'd1);
        chk("d1_ov1", 32'(u_ov), 32'd1);
        chk("d1_od1", 32'(u_od), 32'h01);
        @(posedge CLK); @(negedge CLK);
        u_iv = 1'b0;
        #1;
        chk("d1_ov2", 32'(u_ov), 32'd1);
        chk("d1_od2", 32'(u_od), 32'h02);
        chk("d1_occ2", 32'(u_occ), 32'd1);
        @(posedge CLK); @(negedge CLK);
        chk("d1_ov3", 32'(u_ov), 32'd0);
        chk("d1_occ3", 32'(u_occ), 32'd0);
        u_or = 1'b0; u_iv = 1'b1; u_id = 8'h03;
        @(posedge CLK); @(negedge CLK);
        u_id = 8'h04;
        #1;
        chk("d1_full_ir", 32'(u_ir), 32'd0);
        u_or = 1'b1;
        #1;
        chk("d1_pass_ir", 32'(u_ir), 32'd1);
        @(posedge CLK); @(negedge CLK);
        u_iv = 1'b0;
        #1;
        chk("d1_pass_od", 32'(u_od), 32'h04);
        chk("d1_pass_occ", 32'(u_occ), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pipe_reg_elastic.md
Name: pipe_reg_elastic

Overview:
- Parametrised successor to the fixed inter-stage latches: a DEPTH-deep chain of DATA_W-wide pipeline registers with per-stage valid bits.
- Uses a valid/ready handshake, so stalls propagate as backpressure instead of a global enable.
- Supports synchronous flush (squash) and collapses bubbles internally.
- Sits between any two CPU pipeline stages, for example EX/MEM or MEM/WB, with the stage's control and data fields packed into one bus.

Parameters:
- DATA_W, 32: width of the payload bus carried through each stage.
- DEPTH, 1: number of register stages, legal range 1..4; a violation is an elaboration error.
- BUBBLE_VAL, '0 (DATA_W bits): payload value loaded on reset and on flush, so that control fields decode as a NOP.

Ports:
- CLK  input  1  system clock, rising edge.
- nRST  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream offers in_data this cycle.
- in_ready  output  1  block accepts in_data this cycle (combinational).
- in_data  input  DATA_W  upstream payload.
- flush  input  1  synchronous squash of all held entries.
- out_valid  output  1  stage DEPTH-1 holds a valid entry (registered).
- out_ready  input  1  downstream consumes out_data this cycle.
- out_data  output  DATA_W  payload of stage DEPTH-1 (registered).
- occupancy  output  $clog2(DEPTH+1)  count of valid stages (registered).

Behaviour:
- **State.** Stage k (k=0..DEPTH-1) holds v[k] and d[k]. Stage 0 is the input side; stage DEPTH-1 drives out_valid and out_data.
- **Reset.** nRST low forces, immediately and independent of CLK:
  - all v[k]=0 and all d[k]=BUBBLE_VAL;
  - out_valid=0, out_data=BUBBLE_VAL, occupancy=0.
  - A reset asserted mid-transfer discards all entries; no partial state survives. in_ready is 1 while in reset.
- **Advance rule.**
  - Output stage: adv[DEPTH-1] = v[DEPTH-1] && out_ready.
  - Other stages: stage k moves its entry to k+1 when v[k] && (!v[k+1] || adv[k+1]).
  - Bubble collapse: an invalid stage always accepts from the stage behind it, so gaps close while the output is stalled.
- **Input.** in_ready = !v[0] || adv[0]. A transfer occurs when in_valid && in_ready; stage 0 then loads in_data with v[0]=1.
- **Invalidation.** A stage that is vacated and not refilled clears v[k]. Its d[k] holds its old value, which is don't-care while invalid. out_data is held stable whenever out_valid && !out_ready.
- **Latency and throughput.**
  - With out_ready held high, data accepted at edge n appears on out_data with out_valid=1 after edge n+DEPTH-1; that is, DEPTH cycles of register latency, with a DEPTH=1 entry visible the cycle after acceptance.
  - Sustained throughput is 1 entry per cycle, and there are no bubbles under continuous flow.
- **Flush.** flush=1 at an edge:
  - clears all v[k] and loads all d[k]=BUBBLE_VAL; occupancy becomes 0;
  - forces in_ready=0 that cycle, so no input is accepted;
  - a simultaneous output handshake (out_valid && out_ready) still counts as consumed downstream.
  - flush takes priority over every advance and input transfer.
- **Occupancy.**
  - Next value = occupancy + (input transfer) - (output handshake); it is 0 after flush.
  - It never exceeds DEPTH and never underflows.
  - Accept and consume in the same cycle leave it unchanged.
- **Full.** When occupancy=DEPTH and out_ready=0, in_ready=0. When occupancy=DEPTH and out_ready=1, in_ready=1 (pass-through, with no dead cycle).
- **Empty.** When occupancy=0, out_valid=0 and out_ready is ignored.
- **Invariants.** No combinational path exists from in_data to out_data. The only combinational path is out_ready to in_ready.

Test Plan:
- **Reset values.** DEPTH=3, DATA_W=8, BUBBLE_VAL=8'h00. Assert nRST low asynchronously between edges → out_valid=0, out_data=8'h00, occupancy=0 immediately, and in_ready=1 after release.
- **Streaming.** Same config. Send 8'hA1,8'hA2,8'hA3,8'hA4 on consecutive cycles with out_ready=1 → out_data shows A1..A4 on consecutive cycles, out_valid 1 for exactly 4 cycles, and A1 appears 3 cycles after acceptance; occupancy peaks at 3.
- **Backpressure and full.** Same config with out_ready=0. Send 8'h10,8'h11,8'h12,8'h13 → first three accepted, in_ready=0 with 8'h13 pending, occupancy=3. Then raise out_ready for 4 cycles → outputs 10,11,12,13 in order, with 8'h13 accepted in the same cycle that 10 drains.
- **Bubble collapse.** Same config with out_ready=0. Send 8'h20, idle 1 cycle, send 8'h21 → within 2 further cycles 8'h20 sits in stage 2 and 8'h21 in stage 1, occupancy=2, and in_ready stays 1.
- **Flush mid-stream.** Same config with occupancy=3. Assert flush=1 with out_ready=1 and in_valid=1 (8'hFF) → that edge consumes the current out_data, the next cycle shows occupancy=0 and out_valid=0, and 8'hFF is never accepted.
- **Reset mid-operation and DEPTH=1 corner.** With occupancy=2, pulse nRST low for half a cycle → all entries lost and the next accepted 8'h55 exits normally. With DEPTH=1 and out_ready=1 continuously, back-to-back inputs 8'h01,8'h02 produce 1 entry/cycle, with in_ready held 1.
